// File: rtl/ip_yuv_422_ctrl.sv
// Timing controller for a yuv444-to-422 converter: issues pixels in pairs per line and frame,
// with line/frame blanking, one-shot or continuous operation and a deferred stop.
module ip_yuv_422_ctrl (
  input  logic        yuv_422_ctrl_clk,
  input  logic        yuv_422_ctrl_rst_n,
  input  logic        r_start,
  input  logic        r_stop,
  input  logic        r_cont,
  input  logic [11:0] r_hsize,
  input  logic [11:0] r_vsize,
  input  logic [7:0]  r_hblk,
  input  logic [7:0]  r_vblk,
  input  logic        i_src_rdy,
  output logic        o_vstr,
  output logic        o_vend,
  output logic        o_hstr,
  output logic        o_hend,
  output logic        o_dvld,
  output logic        o_src_rd,
  output logic        o_busy,
  output logic        o_frm_done,
  output logic [11:0] o_hcnt,
  output logic [11:0] o_vcnt
);

  typedef enum logic [1:0] {StIdle, StActv, StHblk, StVblk} state_e;

  state_e      state_q, state_d;
  logic [11:0] hsize_q, vsize_q, hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [7:0]  hblk_q, vblk_q, blk_q, blk_d;
  logic        cont_q, stop_q, stop_d, load;
  logic        vstr_q, vstr_d, vend_q, vend_d, hstr_q, hstr_d, hend_q, hend_d;
  logic        dvld_q, dvld_d, done_q, done_d;

  logic [11:0] hsize_eff;
  logic        cfg_ok, issue, last_pix, last_line;

  assign hsize_eff = {r_hsize[11:1], 1'b0};
  assign cfg_ok    = (hsize_eff >= 12'd2) && (r_vsize != 12'd0);
  // Odd pixels never stall, so gaps only ever fall between pairs.
  assign issue     = (state_q == StActv) && (hcnt_q[0] || i_src_rdy);
  assign last_pix  = (hcnt_q == hsize_q - 12'd1);
  assign last_line = (vcnt_q == vsize_q - 12'd1);

  always_ff @(posedge yuv_422_ctrl_clk or negedge yuv_422_ctrl_rst_n) begin
    if (!yuv_422_ctrl_rst_n) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      blk_q   <= '0;
      stop_q  <= 1'b0;
      hsize_q <= '0;
      vsize_q <= '0;
      hblk_q  <= '0;
      vblk_q  <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      blk_q   <= blk_d;
      stop_q  <= stop_d;
      if (load) begin
        hsize_q <= hsize_eff;
        vsize_q <= r_vsize;
        hblk_q  <= r_hblk;
        vblk_q  <= r_vblk;
        cont_q  <= r_cont;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    blk_d   = blk_q;
    load    = 1'b0;
    stop_d  = stop_q | (r_stop && (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        stop_d = 1'b0;
        if (r_start && cfg_ok) begin
          state_d = StActv;
          load    = 1'b1;
          hcnt_d  = '0;
          vcnt_d  = '0;
          stop_d  = r_stop;
        end
      end
      StActv: begin
        if (issue) begin
          if (last_pix) begin
            hcnt_d = '0;
            if (last_line) begin
              state_d = StVblk;
              blk_d   = (vblk_q == 8'd0) ? 8'd0 : vblk_q - 8'd1;
            end else begin
              vcnt_d = vcnt_q + 12'd1;
              if (hblk_q != 8'd0) begin
                state_d = StHblk;
                blk_d   = hblk_q - 8'd1;
              end
            end
          end else begin
            hcnt_d = hcnt_q + 12'd1;
          end
        end
      end
      StHblk: begin
        if (blk_q == 8'd0) state_d = StActv;
        else               blk_d   = blk_q - 8'd1;
      end
      StVblk: begin
        if (blk_q == 8'd0) begin
          hcnt_d = '0;
          vcnt_d = '0;
          if (cont_q && !stop_d && cfg_ok) begin
            state_d = StActv;
            load    = 1'b1;
          end else begin
            state_d = StIdle;
            stop_d  = 1'b0;
          end
        end else begin
          blk_d = blk_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dvld_d = issue;
    hstr_d = issue && (hcnt_q == 12'd0);
    hend_d = issue && last_pix;
    vstr_d = hstr_d && (vcnt_q == 12'd0);
    vend_d = hend_d && last_line;
    done_d = (state_q == StVblk) && (blk_q == 8'd0);
  end

  always_ff @(posedge yuv_422_ctrl_clk or negedge yuv_422_ctrl_rst_n) begin
    if (!yuv_422_ctrl_rst_n) begin
      vstr_q <= 1'b0;
      vend_q <= 1'b0;
      hstr_q <= 1'b0;
      hend_q <= 1'b0;
      dvld_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      vstr_q <= vstr_d;
      vend_q <= vend_d;
      hstr_q <= hstr_d;
      hend_q <= hend_d;
      dvld_q <= dvld_d;
      done_q <= done_d;
    end
  end

  assign o_vstr     = vstr_q;
  assign o_vend     = vend_q;
  assign o_hstr     = hstr_q;
  assign o_hend     = hend_q;
  assign o_dvld     = dvld_q;
  assign o_src_rd   = dvld_q;
  assign o_frm_done = done_q;
  assign o_busy     = (state_q != StIdle);
  assign o_hcnt     = hcnt_q;
  assign o_vcnt     = vcnt_q;

endmodule

// File: tb/tb_ip_yuv_422_ctrl.sv
// Directed bench for ip_yuv_422_ctrl: a table of frame configurations with hand-computed
// strobe counts, latencies and dvld patterns, plus a mid-frame reset sequence.
module tb_ip_yuv_422_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_start = 1'b0, r_stop = 1'b0, r_cont = 1'b0;
  logic [11:0] r_hsize = '0, r_vsize = '0;
  logic [7:0]  r_hblk = '0, r_vblk = '0;
  logic        i_src_rdy = 1'b1;
  logic        o_vstr, o_vend, o_hstr, o_hend, o_dvld, o_src_rd, o_busy, o_frm_done;
  logic [11:0] o_hcnt, o_vcnt;

  ip_yuv_422_ctrl dut (
    .yuv_422_ctrl_clk  (clk),
    .yuv_422_ctrl_rst_n(rst_n),
    .r_start           (r_start),
    .r_stop            (r_stop),
    .r_cont            (r_cont),
    .r_hsize           (r_hsize),
    .r_vsize           (r_vsize),
    .r_hblk            (r_hblk),
    .r_vblk            (r_vblk),
    .i_src_rdy         (i_src_rdy),
    .o_vstr            (o_vstr),
    .o_vend            (o_vend),
    .o_hstr            (o_hstr),
    .o_hend            (o_hend),
    .o_dvld            (o_dvld),
    .o_src_rd          (o_src_rd),
    .o_busy            (o_busy),
    .o_frm_done        (o_frm_done),
    .o_hcnt            (o_hcnt),
    .o_vcnt            (o_vcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hsize, vsize, hblk, vblk, cont, stop_at, rdy_mode;
    int pix, hs, he, vs, ve, done, lat, busy, hmax, vmax, chk_pat;
    logic [31:0] pat;
  } vec_t;

  vec_t vecs[10];
  int   n_pass = 0, n_total = 0;
  int   r_pix, r_hs, r_he, r_vs, r_ve, r_done, r_lat, r_busy, r_hmax, r_vmax, r_rderr;
  logic [31:0] r_pat;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic vec_t mk(input int h, input int v, input int hb, input int vb, input int ct,
                              input int st, input int rm, input int px, input int hs,
                              input int vs, input int dn, input int lt, input int bz,
                              input int hm, input int vm, input int cp, input logic [31:0] pt);
    vec_t t;
    t.hsize = h; t.vsize = v; t.hblk = hb; t.vblk = vb; t.cont = ct; t.stop_at = st;
    t.rdy_mode = rm; t.pix = px; t.hs = hs; t.he = hs; t.vs = vs; t.ve = vs; t.done = dn;
    t.lat = lt; t.busy = bz; t.hmax = hm; t.vmax = vm; t.chk_pat = cp; t.pat = pt;
    return t;
  endfunction

  task automatic set_cfg(input vec_t v);
    r_hsize = 12'(v.hsize); r_vsize = 12'(v.vsize);
    r_hblk  = 8'(v.hblk);   r_vblk  = 8'(v.vblk);
    r_cont  = (v.cont != 0);
  endtask

  // Cycle 0 is the r_start sample cycle; outputs are sampled on each later falling edge.
  task automatic run_frame(input vec_t v);
    int low2 = 0, low3 = 0;
    r_pix = 0; r_hs = 0; r_he = 0; r_vs = 0; r_ve = 0; r_done = 0; r_lat = 0;
    r_busy = 0; r_hmax = 0; r_vmax = 0; r_rderr = 0; r_pat = '0;
    @(negedge clk);
    set_cfg(v);
    i_src_rdy = 1'b1;
    r_start   = 1'b1;
    r_stop    = (v.stop_at == -1);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      r_start = 1'b0;
      r_stop  = (c == v.stop_at);
      if (c == 2) begin
        r_hsize = 12'd10; r_vsize = 12'd1; r_hblk = 8'd0; r_vblk = 8'd9; r_cont = ~r_cont;
      end
      if (c == 11) set_cfg(v);
      r_pix += int'(o_dvld); r_hs += int'(o_hstr); r_he += int'(o_hend);
      r_vs += int'(o_vstr);  r_ve += int'(o_vend); r_done += int'(o_frm_done);
      if (o_dvld != o_src_rd) r_rderr++;
      if (o_busy) r_busy = 1;
      if (o_frm_done && r_lat == 0) r_lat = c;
      if (o_dvld && c < 32) r_pat[c] = 1'b1;
      if (int'(o_hcnt) > r_hmax) r_hmax = int'(o_hcnt);
      if (int'(o_vcnt) > r_vmax) r_vmax = int'(o_vcnt);
      if (v.rdy_mode == 1 && o_busy && o_hcnt == 12'd2 && low2 < 3) begin
        i_src_rdy = 1'b0; low2++;
      end else if (v.rdy_mode == 1 && o_busy && o_hcnt == 12'd3 && low3 < 3) begin
        i_src_rdy = 1'b0; low3++;
      end else begin
        i_src_rdy = 1'b1;
      end
    end
  endtask

  initial begin
    int found;
    int idle_act;
    //          h  v  hb vb ct stop rm  pix hs vs dn lat bz hm vm cp pattern
    vecs[0] = mk(4, 2, 2, 3, 0,  0, 0,   8, 2, 1, 1, 14, 1, 3, 1, 1, 32'h0000_0F3C);
    vecs[1] = mk(5, 1, 0, 0, 0,  0, 0,   4, 1, 1, 1,  6, 1, 3, 0, 1, 32'h0000_003C);
    vecs[2] = mk(1, 3, 0, 0, 0,  0, 0,   0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h0);
    vecs[3] = mk(6, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h0);
    vecs[4] = mk(2, 3, 1, 2, 0,  0, 0,   6, 3, 1, 1, 11, 1, 1, 2, 1, 32'h0000_036C);
    vecs[5] = mk(8, 2, 0, 5, 0,  0, 0,  16, 2, 1, 1, 22, 1, 7, 1, 1, 32'h0003_FFFC);
    vecs[6] = mk(6, 1, 0, 0, 0,  0, 1,   6, 1, 1, 1, 11, 1, 5, 0, 1, 32'h0000_078C);
    vecs[7] = mk(4, 2, 2, 3, 1,  2, 0,   8, 2, 1, 1, 14, 1, 3, 1, 1, 32'h0000_0F3C);
    vecs[8] = mk(4, 2, 0, 0, 1, -1, 0,   8, 2, 1, 1, 10, 1, 3, 1, 1, 32'h0000_03FC);
    vecs[9] = mk(4, 2, 2, 3, 1, 16, 0,  16, 4, 2, 2, 14, 1, 3, 1, 1, 32'h01E7_8F3C);

    #1;
    chk("reset outputs", int'({o_vstr, o_vend, o_hstr, o_hend, o_dvld, o_src_rd, o_busy,
                               o_frm_done, o_hcnt, o_vcnt}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i]);
      chk($sformatf("v%0d pixels", i), r_pix, vecs[i].pix);
      chk($sformatf("v%0d hstr", i), r_hs, vecs[i].hs);
      chk($sformatf("v%0d hend", i), r_he, vecs[i].he);
      chk($sformatf("v%0d vstr", i), r_vs, vecs[i].vs);
      chk($sformatf("v%0d vend", i), r_ve, vecs[i].ve);
      chk($sformatf("v%0d frm_done", i), r_done, vecs[i].done);
      chk($sformatf("v%0d done cycle", i), r_lat, vecs[i].lat);
      chk($sformatf("v%0d busy seen", i), r_busy, vecs[i].busy);
      chk($sformatf("v%0d busy at end", i), int'(o_busy), 0);
      chk($sformatf("v%0d src_rd==dvld", i), r_rderr, 0);
      chk($sformatf("v%0d hcnt max", i), r_hmax, vecs[i].hmax);
      chk($sformatf("v%0d vcnt max", i), r_vmax, vecs[i].vmax);
      if (vecs[i].chk_pat != 0) chk($sformatf("v%0d dvld pattern", i), int'(r_pat),
                                    int'(vecs[i].pat));
    end

    // Reset at hcnt=3 of line 1, then a normal frame from line 0.
    found = 0;
    @(negedge clk);
    set_cfg(vecs[0]);
    r_start = 1'b1;
    for (int c = 1; c <= 30 && found == 0; c++) begin
      @(negedge clk);
      r_start = 1'b0;
      if (o_busy && o_vcnt == 12'd1 && o_hcnt == 12'd3) found = c;
    end
    chk("reset point cycle", found, 10);
    rst_n = 1'b0;
    #1;
    chk("mid-frame reset outputs", int'({o_vstr, o_vend, o_hstr, o_hend, o_dvld, o_src_rd,
                                         o_busy, o_frm_done, o_hcnt, o_vcnt}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_act = 0;
    for (int c = 0; c < 6; c++) begin
      r_stop = (c == 2);
      @(negedge clk);
      if (o_dvld || o_busy || o_hstr || o_vstr || o_frm_done) idle_act++;
    end
    r_stop = 1'b0;
    chk("quiet after reset", idle_act, 0);
    run_frame(vecs[0]);
    chk("post-reset pixels", r_pix, 8);
    chk("post-reset vstr", r_vs, 1);
    chk("post-reset done cycle", r_lat, 14);
    chk("post-reset dvld pattern", int'(r_pat), 32'h0F3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
